// File: rtl/score_display_sequencer_pkg.sv
// Shared definitions for the score display sequencer: FSM state encoding,
// requester indices, conversion length and the double-dabble digit adjust.
package score_display_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StConvert = 2'd2,
    StHold    = 2'd3
  } state_e;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned CREDITS    = 0;
  localparam int unsigned BET        = 1;
  localparam int unsigned PAYOUT     = 2;
  localparam int unsigned CONV_LEN   = 8;
  localparam int unsigned CONV_CNT_W = $clog2(CONV_LEN);

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial double-dabble converter: 8-bit unsigned magnitude to three BCD digits,
// one adjust-and-shift per cycle. done_o is high during the final shift cycle and
// bcd_o then carries the finished result (the value the final shift produces).
module bcd_serial_conv
  import score_display_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  logic [7:0]            sr_q, sr_d;
  logic [11:0]           bcd_q, bcd_d;
  logic [CONV_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [19:0]           shifted;

  assign done_o = busy_q && (cnt_q == CONV_CNT_W'(CONV_LEN - 1));
  assign bcd_o  = shifted[19:8];

  // Next-state: load on start, otherwise adjust and shift while busy.
  always_comb begin
    shifted = {dd_adjust(bcd_q), sr_q} << 1;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      sr_d   = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = shifted[7:0];
      bcd_d = shifted[19:8];
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/score_display_sequencer.sv
// Score display sequencer: round-robin arbitration between credits, bet and
// payout values, serial BCD conversion, then a fixed hold before re-arbitrating.
// Optional feature macro SCORE_DISP_BLINK_EN: blinks the display during a payout hold.
module score_display_sequencer
  import score_display_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned BLINK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] val0,
  input  logic [7:0] val1,
  input  logic [7:0] val2,
  output logic [2:0] ack,
  output logic [3:0] dig_ones,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_hund,
  output logic       neg,
  output logic       valid,
  output logic       busy,
  output logic       blank
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, grant_q, win, ptr_next;
  logic [HoldW-1:0] hold_cnt_q;
  logic             sign_q;
  logic [7:0]       val_sel, mag;
  logic             conv_start, conv_done;
  logic [11:0]      conv_bcd;

  // Round-robin winner: search upward from ptr_q, wrapping past the payout index.
  always_comb begin
    case (ptr_q)
      2'd0:    win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      2'd1:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      default: win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
    endcase
    ptr_next = (win == 2'(PAYOUT)) ? 2'd0 : win + 2'd1;
  end

  // Granted value and its magnitude; -128 negates to 8'h80 = 128 unsigned.
  always_comb begin
    case (grant_q)
      2'(CREDITS): val_sel = val0;
      2'(BET):     val_sel = val1;
      default:     val_sel = val2;
    endcase
    mag = val_sel[7] ? (~val_sel + 8'd1) : val_sel;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; requests are only looked at in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|req) state_d = StGrant;
      StGrant:   state_d = StConvert;
      StConvert: if (conv_done) state_d = StHold;
      StHold:    if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ack        = (state_q == StGrant) ? (3'b001 << grant_q) : 3'b000;
    busy       = (state_q != StIdle);
    conv_start = (state_q == StGrant);
  end

  // Arbitration, sign capture, atomic display update and hold counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      sign_q     <= 1'b0;
      hold_cnt_q <= '0;
      dig_ones   <= '0;
      dig_tens   <= '0;
      dig_hund   <= '0;
      neg        <= 1'b0;
      valid      <= 1'b0;
    end else begin
      if (state_q == StIdle && (|req)) begin
        grant_q <= win;
        ptr_q   <= ptr_next;
      end
      if (state_q == StGrant) begin
        sign_q <= val_sel[7];
      end
      if (state_q == StConvert && conv_done) begin
        dig_ones <= conv_bcd[3:0];
        dig_tens <= conv_bcd[7:4];
        dig_hund <= conv_bcd[11:8];
        neg      <= sign_q;
        valid    <= 1'b1;
      end
      hold_cnt_q <= (state_q == StHold) ? hold_cnt_q + 1'b1 : '0;
    end
  end

  bcd_serial_conv u_conv (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (conv_start),
    .bin_i   (mag),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef SCORE_DISP_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blank_q;

  // Payout hold blinks: blank starts high and toggles every BLINK_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (state_d == StHold && grant_q == 2'(PAYOUT)) begin
      if (state_q != StHold) begin
        blink_cnt_q <= '0;
        blank_q     <= 1'b1;
      end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end
  end

  assign blank = blank_q;
`else
  // Blinking not built; the parameter stays for a uniform interface.
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_CYCLES;
  assign blank            = 1'b0;
`endif

endmodule

// File: tb/tb_score_display_sequencer.sv
// Bench for score_display_sequencer: per-cycle comparison against a
// transaction-timeline reference model, a directed vector table and
// hand-written sequences for round-robin ordering and mid-conversion reset.
module tb_score_display_sequencer;

  localparam int unsigned H  = 5;
  localparam int unsigned BL = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] req  = '0;
  logic [7:0] val0 = '0;
  logic [7:0] val1 = '0;
  logic [7:0] val2 = '0;
  logic [2:0] ack;
  logic [3:0] dig_ones, dig_tens, dig_hund;
  logic       neg, valid, busy, blank;

  always #5 clk = ~clk;

  score_display_sequencer #(
    .HOLD_CYCLES  (H),
    .BLINK_CYCLES (BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .val0     (val0),
    .val1     (val1),
    .val2     (val2),
    .ack      (ack),
    .dig_ones (dig_ones),
    .dig_tens (dig_tens),
    .dig_hund (dig_hund),
    .neg      (neg),
    .valid    (valid),
    .busy     (busy),
    .blank    (blank)
  );

  int n_checks = 0;
  int n_err    = 0;
  int edge_no  = 0;

  // Reference model: grant edge, next idle-sampling edge, pointer, display.
  int         m_g     = -1000;
  int         m_free  = 0;
  int         m_ptr   = 0;
  int         m_win   = 0;
  logic [7:0] m_cap   = '0;
  int         m_ones  = 0;
  int         m_tens  = 0;
  int         m_hund  = 0;
  int         m_neg   = 0;
  int         m_valid = 0;

  typedef struct {
    logic [2:0] req;
    logic [7:0] v;
    logic [2:0] ack;
    int         hund;
    int         tens;
    int         ones;
    logic       neg;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic logic [7:0] cur_val(input int idx);
    return (idx == 0) ? val0 : ((idx == 1) ? val1 : val2);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_g     = -1000;
      m_free  = edge_no + 1;
      m_ptr   = 0;
      m_win   = 0;
      m_ones  = 0;
      m_tens  = 0;
      m_hund  = 0;
      m_neg   = 0;
      m_valid = 0;
    end else begin
      if (edge_no == m_g + 1) m_cap = cur_val(m_win);
      if (edge_no == m_g + 9) begin
        int mag;
        mag     = m_cap[7] ? 256 - int'(m_cap) : int'(m_cap);
        m_hund  = mag / 100;
        m_tens  = (mag / 10) % 10;
        m_ones  = mag % 10;
        m_neg   = int'(m_cap[7]);
        m_valid = 1;
      end
      if (edge_no >= m_free && req != 3'b000) begin
        int found;
        found = 0;
        for (int k = 0; k < 3; k++) begin
          int c;
          c = (m_ptr + k) % 3;
          if (found == 0 && req[c]) begin
            m_win = c;
            found = 1;
          end
        end
        m_ptr  = (m_win + 1) % 3;
        m_g    = edge_no;
        m_free = edge_no + 10 + int'(H);
      end
    end
  endtask

  task automatic compare_all();
    int exp_blank;
    exp_blank = 0;
`ifdef SCORE_DISP_BLINK_EN
    if (m_win == 2 && edge_no >= m_g + 9 && edge_no < m_g + 9 + int'(H))
      exp_blank = (((edge_no - m_g - 9) / int'(BL)) % 2 == 0) ? 1 : 0;
`endif
    chk("ack", 32'(ack), (edge_no == m_g) ? (32'd1 << m_win) : 32'd0);
    chk("dig_ones", 32'(dig_ones), m_ones);
    chk("dig_tens", 32'(dig_tens), m_tens);
    chk("dig_hund", 32'(dig_hund), m_hund);
    chk("neg", 32'(neg), m_neg);
    chk("valid", 32'(valid), m_valid);
    chk("busy", 32'(busy), (edge_no < m_free - 1) ? 32'd1 : 32'd0);
    chk("blank", 32'(blank), exp_blank);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic scramble();
    val0 = 8'($urandom);
    val1 = 8'($urandom);
    val2 = 8'($urandom);
  endtask

  initial begin
    logic [11:0] pv;
    int          idx;

    tbl[0] = '{3'b001, 8'd123, 3'b001, 1, 2, 3, 1'b0};
    tbl[1] = '{3'b010, 8'hF6,  3'b010, 0, 1, 0, 1'b1};
    tbl[2] = '{3'b100, 8'h80,  3'b100, 1, 2, 8, 1'b1};
    tbl[3] = '{3'b001, 8'h00,  3'b001, 0, 0, 0, 1'b0};
    tbl[4] = '{3'b010, 8'h7F,  3'b010, 1, 2, 7, 1'b0};
    tbl[5] = '{3'b100, 8'hFF,  3'b100, 0, 0, 1, 1'b1};
    tbl[6] = '{3'b001, 8'd99,  3'b001, 0, 9, 9, 1'b0};
    tbl[7] = '{3'b100, 8'h9C,  3'b100, 1, 0, 0, 1'b1};

    // Reset state.
    rst = 1'b1;
    repeat (2) tick();
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_digits", 32'({dig_hund, dig_tens, dig_ones}), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vector table: ack, no early update, digits after edge N+10.
    pv = '0;
    for (int i = 0; i < 8; i++) begin
      idx = tbl[i].req[0] ? 0 : (tbl[i].req[1] ? 1 : 2);
      scramble();
      if (idx == 0) val0 = tbl[i].v;
      else if (idx == 1) val1 = tbl[i].v;
      else val2 = tbl[i].v;
      req = tbl[i].req;
      tick();
      chk("tbl_ack", 32'(ack), 32'(tbl[i].ack));
      req = 3'b000;
      tick();
      scramble();
      repeat (7) tick();
      chk("tbl_no_early", 32'({dig_hund, dig_tens, dig_ones}), 32'(pv));
      repeat (2) tick();
      pv = {4'(tbl[i].hund), 4'(tbl[i].tens), 4'(tbl[i].ones)};
      chk("tbl_digits", 32'({dig_hund, dig_tens, dig_ones}), 32'(pv));
      chk("tbl_neg", 32'(neg), 32'(tbl[i].neg));
      chk("tbl_valid", 32'(valid), 32'd1);
      repeat (H) tick();
    end

    // All three requesting: round-robin order from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    scramble();
    req = 3'b111;
    tick();
    chk("rr_grant0", 32'(ack), 32'b001);
    repeat (10 + H) tick();
    chk("rr_grant1", 32'(ack), 32'b010);
    repeat (10 + H) tick();
    chk("rr_grant2", 32'(ack), 32'b100);
    repeat (10 + H) tick();
    chk("rr_grant3", 32'(ack), 32'b001);
    req = 3'b000;
    repeat (12 + H) tick();

    // Reset during conversion cycle 4 aborts; the next request converts cleanly.
    val0 = 8'd77;
    req  = 3'b001;
    tick();
    req = 3'b000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_digits", 32'({dig_hund, dig_tens, dig_ones}), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    rst = 1'b0;
    repeat (9) tick();
    chk("rst_no_update", 32'({dig_hund, dig_tens, dig_ones}), 32'd0);
    val1 = 8'hDB;
    req  = 3'b010;
    tick();
    chk("post_rst_ack", 32'(ack), 32'b010);
    req = 3'b000;
    repeat (9) tick();
    chk("post_rst_digits", 32'({dig_hund, dig_tens, dig_ones}), 32'h037);
    chk("post_rst_neg", 32'(neg), 32'd1);
    repeat (H + 1) tick();

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom);
      if ($urandom_range(0, 1) == 0) scramble();
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req = 3'b000;
    repeat (12 + H) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display_sequencer.md
SCORE_DISPLAY_SEQUENCER -- requirements
Module: score_display_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, the number of cycles a converted value is held before re-arbitration (minimum 1).
REQ-002 SHALL have parameter BLINK_CYCLES, default 4, the blank-toggle half-period in cycles (only used with SCORE_DISP_BLINK_EN).
REQ-003 SHALL have port clk  input  1  the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  3  level request per requester: 0=credits, 1=bet, 2=payout.
REQ-006 SHALL have ports val0, val1, val2  input  8 each  two's-complement value of each requester.
REQ-007 SHALL have port ack  output  3  one-hot, one-cycle grant pulse.
REQ-008 SHALL have ports dig_ones, dig_tens, dig_hund  output  4 each  BCD magnitude digits.
REQ-009 SHALL have port neg  output  1  sign of the displayed value.
REQ-010 SHALL have port valid  output  1  high once the first conversion completes.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port blank  output  1  display blanking request.

Function
REQ-013 SHALL implement states IDLE, GRANT, CONVERT, HOLD.
REQ-014 IDLE: if any req bit is high at a rising edge, SHALL move to GRANT; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration: round-robin, searching upward from the index after the last granted requester. After reset the search SHALL start at index 0.
REQ-016 GRANT: SHALL last exactly one cycle, assert ack for the winner only, and capture its val and sign.
REQ-017 Magnitude: SHALL be the two's-complement negation for negative inputs and the input itself otherwise. Input -128 SHALL give magnitude 128, neg=1.
REQ-018 CONVERT: SHALL perform serial double-dabble, one shift per cycle, exactly 8 cycles, with add-3 applied to each digit >=5 before each shift.
REQ-019 Outputs dig_*, neg: SHALL update atomically on the edge leaving CONVERT. They SHALL never show intermediate values.
REQ-020 Latency: a request sampled at edge N SHALL give ack high during cycle N+1 and new digits visible after edge N+10.
REQ-021 HOLD: SHALL remain for exactly HOLD_CYCLES cycles, then return to IDLE. Requests SHALL be ignored during GRANT, CONVERT and HOLD but stay pending because they are level-sensitive.
REQ-022 A requester deasserting req before being granted SHALL NOT be served. A value change after ack SHALL NOT affect the current conversion.
REQ-023 Between conversions SHALL retain the last displayed value. valid, once set, SHALL stay high until reset.
REQ-024 Zero SHALL display 0/0/0 with neg=0.

Reset
REQ-025 rst SHALL force: state=IDLE, ack=0, dig_*=0, neg=0, valid=0, busy=0, blank=0, round-robin pointer=index 0, counters=0.
REQ-026 rst asserted mid-CONVERT or mid-HOLD SHALL abort the operation with no output update. The next request after release SHALL follow REQ-020.

Configuration
REQ-027 With SCORE_DISP_BLINK_EN defined: during HOLD for requester 2 only, blank SHALL toggle every BLINK_CYCLES cycles, starting high. blank SHALL be 0 in all other states and for other requesters.
REQ-028 Without SCORE_DISP_BLINK_EN: blank SHALL be constant 0, and no blink counter SHALL be synthesised.

Structure
REQ-029 A shared package SHALL hold the state encoding, requester index constants (CREDITS=0, BET=1, PAYOUT=2) and the conversion length constant 8.
REQ-030 The double-dabble shifter SHALL be one sub-module, bcd_serial_conv, with start/done handshake. The arbiter and FSM SHALL stay in the top module.

Verification
REQ-031 Scenario: reset, then req=001, val0=8'd123 -> ack=001 at cycle 1; after edge 10, digits 1/2/3, neg=0, valid=1.
REQ-032 Scenario: req=010, val1=8'hF6 -> digits 0/1/0, neg=1.
REQ-033 Scenario: val2=8'h80 -> digits 1/2/8, neg=1. Separately, val=0 -> 0/0/0, neg=0.
REQ-034 Scenario: req=111 held -> grants in order 001, 010, 100, 001, spaced 10+HOLD_CYCLES cycles apart.
REQ-035 Scenario: rst pulsed at CONVERT cycle 4 -> all outputs at reset values, no digit update. The next request converts correctly.
REQ-036 Scenario: with SCORE_DISP_BLINK_EN, payout request, BLINK_CYCLES=4 -> blank high 4, low 4, ... through HOLD. Without the macro, blank stays 0.
